elevator_request_sequencer: RTL and testbench
=============================================

ELEVATOR_REQUEST_SEQUENCER -- requirements
Module: elevator_request_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning number of queued trip requests.
REQ-002 SHALL have parameter TIMEOUT, default 16'd1000, meaning max wait cycles per wait state.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  async active-low reset.
REQ-004 SHALL have req_valid  input  1  trip request offered.
REQ-005 SHALL have req_ready  output  1  request accepted when high with req_valid.
REQ-006 SHALL have req_src  input  2  pickup floor, 1..3.
REQ-007 SHALL have req_dst  input  2  destination floor, 1..3.
REQ-008 SHALL have floor  input  3  controller floor, one-hot: 3'b100=F1, 3'b010=F2, 3'b001=F3.
REQ-009 SHALL have door  input  1  controller door, 1=open.
REQ-010 SHALL have floor_button_pressed  output  4  hall pulses: bit3 F1 up, bit2 F2 down, bit1 F2 up, bit0 F3 down.
REQ-011 SHALL have elevator_floor_button_pressed  output  3  car pulses: bit2 F1, bit1 F2, bit0 F3.
REQ-012 SHALL have trip_done  output  1  one-cycle pulse, trip completed.
REQ-013 SHALL have trip_timeout  output  1  one-cycle pulse, trip abandoned.
REQ-014 SHALL have req_err  output  1  one-cycle pulse, invalid request dropped.
REQ-015 SHALL have trip_cycles  output  16  cycles from hall pulse to arrival, held until next trip_done.
REQ-016 SHALL have busy  output  1  FSM not in IDLE.

Function
REQ-017 SHALL sample all inputs on rising clk; all outputs SHALL be registered.
REQ-018 SHALL accept a request when req_valid && req_ready; req_ready = FIFO not full, independent of req_valid.
REQ-019 SHALL drop a request with src==0, dst==0 or src==dst at acceptance, pulse req_err the next cycle, not enqueue it.
REQ-020 SHALL hold accepted requests in a FIFO of FIFO_DEPTH entries, in order; pointers wrap modulo FIFO_DEPTH.
REQ-021 SHALL implement FSM states IDLE, HALL_PRESS, WAIT_PICKUP, CAR_PRESS, WAIT_DROP, DONE.
REQ-022 IDLE -> HALL_PRESS when FIFO non-empty; pop on this transition; request accepted at edge N SHALL produce hall pulse in cycle N+2 when FIFO empty and IDLE.
REQ-023 HALL_PRESS SHALL last one cycle, drive exactly one hall bit: src1 -> bit3; src2 dst3 -> bit1; src2 dst1 -> bit2; src3 -> bit0; then WAIT_PICKUP.
REQ-024 WAIT_PICKUP -> CAR_PRESS when floor equals one-hot(src) and door==1.
REQ-025 CAR_PRESS SHALL last one cycle, drive exactly the dst car bit; then WAIT_DROP.
REQ-026 WAIT_DROP -> DONE when floor equals one-hot(dst) and door==1; DONE pulses trip_done, updates trip_cycles, -> IDLE.
REQ-027 SHALL count trip_cycles from the HALL_PRESS cycle (=1) through the arrival-detect cycle, saturating at 16'hFFFF.
REQ-028 SHALL keep a wait counter, cleared on entering each wait state; at TIMEOUT cycles in either wait state SHALL pulse trip_timeout, -> IDLE, no further button pulse for that trip, trip_cycles unchanged.
REQ-029 Simultaneous push and pop SHALL both occur; FIFO count unchanged.
REQ-030 All button outputs SHALL be 0 outside HALL_PRESS/CAR_PRESS.

Reset
REQ-031 rst_n low SHALL immediately clear FIFO, FSM to IDLE, all outputs to 0 except req_ready=1; trip_cycles=0.
REQ-032 Reset mid-trip SHALL abandon the trip without trip_done or trip_timeout pulse.

Verification
REQ-033 Reset: hold rst_n low 5 cycles -> all outputs 0, req_ready=1, busy=0.
REQ-034 Trip 3->1: push src=3,dst=1; model floor=3'b001,door=1 -> floor_button_pressed=4'b0001 one cycle, then elevator_floor_button_pressed=3'b100 one cycle; floor=3'b100,door=1 -> trip_done, trip_cycles matches count.
REQ-035 Trip 2->3: push src=2,dst=3 -> 4'b0010 pulse, then 3'b001 pulse, trip_done.
REQ-036 FIFO full: stall in WAIT_PICKUP, push continuously -> exactly 4 accepted, req_ready=0, all 4 serviced in order.
REQ-037 Timeout (TIMEOUT=20): never arrive -> trip_timeout 20 cycles after WAIT_PICKUP entry, no car pulse, next queued trip starts.
REQ-038 Invalid src=2,dst=2 -> req_err one cycle, no button pulse, busy stays 0.

Source files
------------

// File: rtl/elevator_request_sequencer.sv
// rtl/elevator_request_sequencer.sv - queues trip requests and sequences hall/car button pulses for an elevator controller
module elevator_request_sequencer #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] TIMEOUT    = 16'd1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_src,
    input  logic [1:0]  req_dst,
    input  logic [2:0]  floor,
    input  logic        door,
    output logic [3:0]  floor_button_pressed,
    output logic [2:0]  elevator_floor_button_pressed,
    output logic        trip_done,
    output logic        trip_timeout,
    output logic        req_err,
    output logic [15:0] trip_cycles,
    output logic        busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        HALL_PRESS,
        WAIT_PICKUP,
        CAR_PRESS,
        WAIT_DROP,
        DONE
    } state_t;

    state_t state, next_state;

    logic [1:0]    fifo_src [FIFO_DEPTH];
    logic [1:0]    fifo_dst [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic [1:0]    cur_src, cur_dst;
    logic [15:0]   wait_cnt, trip_cnt;

    logic accept, req_bad, push, pop;
    logic wait_expired, timeout_fire;
    logic [1:0] head_src, head_dst;

    function automatic logic [2:0] floor_onehot(input logic [1:0] f);
        case (f)
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            2'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Floor 2 has both an up and a down hall button; direction picks which.
    function automatic logic [3:0] hall_code(input logic [1:0] s, input logic [1:0] d);
        case (s)
            2'd1:    return 4'b1000;
            2'd2:    return (d == 2'd3) ? 4'b0010 : 4'b0100;
            2'd3:    return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign accept   = req_valid && req_ready;
    assign req_bad  = (req_src == 2'd0) || (req_dst == 2'd0) || (req_src == req_dst);
    assign push     = accept && !req_bad;
    assign pop      = (state == IDLE) && (count != '0);
    assign head_src = fifo_src[rd_ptr];
    assign head_dst = fifo_dst[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    assign wait_expired = ({1'b0, wait_cnt} + 17'd1) >= {1'b0, TIMEOUT};

    always_comb begin
        next_state   = state;
        timeout_fire = 1'b0;
        case (state)
            IDLE:        if (count != '0) next_state = HALL_PRESS;
            HALL_PRESS:  next_state = WAIT_PICKUP;
            WAIT_PICKUP: begin
                if (floor == floor_onehot(cur_src) && door) begin
                    next_state = CAR_PRESS;
                end else if (wait_expired) begin
                    next_state   = IDLE;
                    timeout_fire = 1'b1;
                end
            end
            CAR_PRESS:   next_state = WAIT_DROP;
            WAIT_DROP: begin
                if (floor == floor_onehot(cur_dst) && door) begin
                    next_state = DONE;
                end else if (wait_expired) begin
                    next_state   = IDLE;
                    timeout_fire = 1'b1;
                end
            end
            DONE:        next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Entry storage carries no reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_src[wr_ptr] <= req_src;
            fifo_dst[wr_ptr] <= req_dst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            cur_src <= 2'd0;
            cur_dst <= 2'd0;
        end else begin
            count <= count_next;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop) begin
                rd_ptr  <= ptr_inc(rd_ptr);
                cur_src <= head_src;
                cur_dst <= head_dst;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 16'd0;
            trip_cnt <= 16'd0;
        end else begin
            if (next_state != state) begin
                wait_cnt <= 16'd0;
            end else if (wait_cnt != 16'hFFFF) begin
                wait_cnt <= wait_cnt + 16'd1;
            end

            if (next_state == HALL_PRESS) begin
                trip_cnt <= 16'd1;
            end else if (state != IDLE && trip_cnt != 16'hFFFF) begin
                trip_cnt <= trip_cnt + 16'd1;
            end
        end
    end

    // Outputs are decoded from next_state so each pulse lines up with its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready                     <= 1'b1;
            floor_button_pressed          <= 4'd0;
            elevator_floor_button_pressed <= 3'd0;
            trip_done                     <= 1'b0;
            trip_timeout                  <= 1'b0;
            req_err                       <= 1'b0;
            trip_cycles                   <= 16'd0;
            busy                          <= 1'b0;
        end else begin
            req_ready                     <= (count_next != CW'(FIFO_DEPTH));
            floor_button_pressed          <= (next_state == HALL_PRESS) ? hall_code(head_src, head_dst) : 4'd0;
            elevator_floor_button_pressed <= (next_state == CAR_PRESS) ? floor_onehot(cur_dst) : 3'd0;
            trip_done                     <= (next_state == DONE);
            trip_timeout                  <= timeout_fire;
            req_err                       <= accept && req_bad;
            busy                          <= (next_state != IDLE);
            if (next_state == DONE) begin
                trip_cycles <= trip_cnt;
            end
        end
    end

endmodule

// File: tb/tb_elevator_request_sequencer.sv
// tb/tb_elevator_request_sequencer.sv - scoreboard bench for elevator_request_sequencer
module tb_elevator_request_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_src;
    logic [1:0]  req_dst;
    logic [2:0]  floor;
    logic        door;
    logic [3:0]  floor_button_pressed;
    logic [2:0]  elevator_floor_button_pressed;
    logic        trip_done;
    logic        trip_timeout;
    logic        req_err;
    logic [15:0] trip_cycles;
    logic        busy;

    elevator_request_sequencer #(
        .FIFO_DEPTH(4),
        .TIMEOUT   (16'd20)
    ) dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .req_valid                    (req_valid),
        .req_ready                    (req_ready),
        .req_src                      (req_src),
        .req_dst                      (req_dst),
        .floor                        (floor),
        .door                         (door),
        .floor_button_pressed         (floor_button_pressed),
        .elevator_floor_button_pressed(elevator_floor_button_pressed),
        .trip_done                    (trip_done),
        .trip_timeout                 (trip_timeout),
        .req_err                      (req_err),
        .trip_cycles                  (trip_cycles),
        .busy                         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] hall;
        logic [2:0] car;
        logic [2:0] src_oh;
        logic [2:0] dst_oh;
    } trip_t;

    trip_t       exp_q[$];
    trip_t       cur;
    bit          cur_active = 1'b0;
    bit          car_seen   = 1'b0;
    bit          auto_serve = 1'b0;
    int          cyc        = 0;
    int          hall_cyc   = 0;
    int          n_done     = 0;
    int          n_tmo      = 0;
    int          n_err      = 0;
    int          exp_done   = 0;
    int          n_checks   = 0;
    int          n_errors   = 0;
    logic [15:0] last_cycles = 16'd0;
    logic [3:0]  prev_hall   = 4'd0;
    logic [2:0]  prev_car    = 3'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] oh(input logic [1:0] f);
        case (f)
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            2'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [3:0] hall_model(input logic [1:0] s, input logic [1:0] d);
        if (s == 2'd1) return 4'b1000;
        if (s == 2'd3) return 4'b0001;
        return (d == 2'd3) ? 4'b0010 : 4'b0100;
    endfunction

    function automatic trip_t make_trip(input logic [1:0] s, input logic [1:0] d);
        trip_t t;
        t.hall   = hall_model(s, d);
        t.car    = oh(d);
        t.src_oh = oh(s);
        t.dst_oh = oh(d);
        return t;
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard plus elevator model: only this block drives floor/door.
    always @(negedge clk) begin
        if (!rst_n) begin
            cur_active = 1'b0;
            car_seen   = 1'b0;
        end else begin
            if (floor_button_pressed != 4'd0) begin
                if (prev_hall != 4'd0) check_eq("hall_one_cycle", floor_button_pressed, 4'd0);
                if (exp_q.size() == 0) begin
                    check_eq("hall_unexpected", floor_button_pressed, 4'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check_eq("hall_code", floor_button_pressed, cur.hall);
                    cur_active = 1'b1;
                    car_seen   = 1'b0;
                    hall_cyc   = cyc;
                end
            end
            if (elevator_floor_button_pressed != 3'd0) begin
                if (!cur_active || car_seen || prev_car != 3'd0) begin
                    check_eq("car_unexpected", elevator_floor_button_pressed, 3'd0);
                end else begin
                    check_eq("car_code", elevator_floor_button_pressed, cur.car);
                    car_seen = 1'b1;
                end
            end
            if (trip_done) begin
                check_eq("done_after_car", car_seen, 1);
                check_eq("trip_cycles", trip_cycles, cyc - hall_cyc);
                last_cycles = trip_cycles;
                n_done++;
                cur_active = 1'b0;
            end
            if (trip_timeout) begin
                check_eq("timeout_delay", cyc - hall_cyc, 21);
                check_eq("timeout_no_car", car_seen, 0);
                check_eq("timeout_cycles_held", trip_cycles, last_cycles);
                n_tmo++;
                cur_active = 1'b0;
            end
            if (req_err) n_err++;
        end
        prev_hall = floor_button_pressed;
        prev_car  = elevator_floor_button_pressed;
        if (auto_serve && cur_active) begin
            floor = car_seen ? cur.dst_oh : cur.src_oh;
            door  = 1'b1;
        end else begin
            if (floor === 3'bxxx) floor = 3'b010;
            door = 1'b0;
        end
    end

    task automatic push(input logic [1:0] s, input logic [1:0] d);
        bit rdy;
        int guard;
        guard = 0;
        @(negedge clk);
        req_src   = s;
        req_dst   = d;
        req_valid = 1'b1;
        forever begin
            rdy = req_ready;
            @(posedge clk);
            if (rdy) break;
            guard++;
            if (guard > 200) begin
                check_eq("push_ready_timeout", 0, 1);
                break;
            end
            @(negedge clk);
        end
        #1 req_valid = 1'b0;
        if (s != 2'd0 && d != 2'd0 && s != d) exp_q.push_back(make_trip(s, d));
    endtask

    task automatic wait_done(input int target);
        int budget;
        budget = 500;
        while (n_done < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check_eq("wait_done_timeout", n_done, target);
    endtask

    task automatic wait_hall();
        int budget;
        budget = 50;
        do begin
            @(negedge clk);
            budget--;
        end while (floor_button_pressed == 4'd0 && budget > 0);
        if (budget == 0) check_eq("wait_hall_timeout", floor_button_pressed, 4'hF);
    endtask

    logic [1:0] fill_src [6] = '{2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1};
    logic [1:0] fill_dst [6] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};

    initial begin
        int acc;
        int budget;
        bit rdy;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_src   = 2'd0;
        req_dst   = 2'd0;
        floor     = 3'b010;
        door      = 1'b0;

        repeat (5) @(negedge clk);
        check_eq("rst_hall", floor_button_pressed, 4'd0);
        check_eq("rst_car", elevator_floor_button_pressed, 3'd0);
        check_eq("rst_done", trip_done, 0);
        check_eq("rst_timeout", trip_timeout, 0);
        check_eq("rst_err", req_err, 0);
        check_eq("rst_cycles", trip_cycles, 16'd0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", req_ready, 1);
        rst_n = 1'b1;

        // Trip 3->1 with first-request latency
        auto_serve = 1'b1;
        push(2'd3, 2'd1);
        @(negedge clk);
        check_eq("lat_idle", floor_button_pressed, 4'd0);
        @(negedge clk);
        check_eq("lat_hall", floor_button_pressed, 4'b0001);
        check_eq("busy_in_trip", busy, 1);
        exp_done = 1;
        wait_done(exp_done);

        // Trip 2->3
        push(2'd2, 2'd3);
        exp_done = 2;
        wait_done(exp_done);

        // Invalid requests
        push(2'd2, 2'd2);
        @(negedge clk);
        check_eq("err_pulse", req_err, 1);
        check_eq("err_busy", busy, 0);
        @(negedge clk);
        check_eq("err_one_cycle", req_err, 0);
        push(2'd0, 2'd1);
        push(2'd1, 2'd0);
        repeat (3) @(negedge clk);
        check_eq("err_idle_busy", busy, 0);

        // FIFO full while first trip stalls in WAIT_PICKUP
        auto_serve = 1'b0;
        push(2'd1, 2'd3);
        wait_hall();
        acc       = 0;
        req_src   = fill_src[0];
        req_dst   = fill_dst[0];
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rdy = req_ready;
            @(posedge clk);
            if (rdy) begin
                exp_q.push_back(make_trip(req_src, req_dst));
                acc++;
            end
            @(negedge clk);
            req_src = fill_src[acc];
            req_dst = fill_dst[acc];
        end
        check_eq("fifo_accepts", acc, 4);
        check_eq("fifo_full_ready", req_ready, 0);
        req_valid  = 1'b0;
        auto_serve = 1'b1;
        exp_done   = exp_done + 5;
        wait_done(exp_done);
        check_eq("fifo_ready_back", req_ready, 1);

        // Timeout on a trip that never gets a pickup, then the next trip runs
        auto_serve = 1'b0;
        push(2'd1, 2'd2);
        push(2'd3, 2'd2);
        budget = 100;
        do begin
            @(negedge clk);
            budget--;
        end while (!trip_timeout && budget > 0);
        if (budget == 0) check_eq("wait_timeout_pulse", trip_timeout, 1);
        auto_serve = 1'b1;
        exp_done   = exp_done + 1;
        wait_done(exp_done);

        // Reset in the middle of a trip
        auto_serve = 1'b0;
        push(2'd2, 2'd1);
        wait_hall();
        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_ready", req_ready, 1);
        check_eq("rst_mid_cycles", trip_cycles, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        check_eq("queue_drained", exp_q.size(), 0);
        check_eq("done_count", n_done, exp_done);
        check_eq("timeout_count", n_tmo, 1);
        check_eq("err_count", n_err, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
